// File: rtl/vga_pkg.sv
// Shared timing descriptions and helpers for the VGA scan generator.
package vga_pkg;

    typedef struct packed {
        logic [11:0] active;
        logic [11:0] fp;
        logic [11:0] sync;
        logic [11:0] bp;
    } vga_axis_t;

    typedef struct packed {
        vga_axis_t h;
        vga_axis_t v;
    } vga_timing_t;

    localparam vga_timing_t VGA_640x480_60 = '{
        h: '{12'd640, 12'd16, 12'd96, 12'd48},
        v: '{12'd480, 12'd10, 12'd2,  12'd33}
    };

    localparam vga_timing_t QVGA_320x240 = '{
        h: '{12'd320, 12'd8, 12'd48, 12'd24},
        v: '{12'd240, 12'd5, 12'd1,  12'd16}
    };

    // log2 of the power-of-two replication factor
    function automatic int scale_shift(input int scale);
        return $clog2(scale);
    endfunction

    // {R,G,B} on/off mask for each of the eight vertical colour bars
    function automatic logic [2:0] bar_rgb(input logic [2:0] bar);
        logic [2:0] m;
        case (bar)
            3'd0:    m = 3'b111;
            3'd1:    m = 3'b110;
            3'd2:    m = 3'b011;
            3'd3:    m = 3'b010;
            3'd4:    m = 3'b101;
            3'd5:    m = 3'b100;
            3'd6:    m = 3'b001;
            default: m = 3'b000;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/sync_delay.sv
// Enable-gated shift register with async clear; DEPTH=0 is a plain wire.
module sync_delay #(
    parameter int DEPTH = 1,
    parameter int WIDTH = 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    generate
        if (DEPTH == 0) begin : g_pass
            assign o_q = i_d;
        end else begin : g_shift
            logic [WIDTH-1:0] r_stage [DEPTH];

            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    for (int i = 0; i < DEPTH; i++) r_stage[i] <= '0;
                end else if (i_en) begin
                    r_stage[0] <= i_d;
                    for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
                end
            end

            assign o_q = r_stage[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_scan_gen.sv
// Parametrised VGA raster generator with pixel replication and read-latency alignment.
// Optional build macro TEST_PATTERN_EN adds a test_mode input selecting 8 colour bars.
module vga_scan_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = int'(VGA_640x480_60.h.active),
    parameter int H_FP     = int'(VGA_640x480_60.h.fp),
    parameter int H_SYNC   = int'(VGA_640x480_60.h.sync),
    parameter int H_BP     = int'(VGA_640x480_60.h.bp),
    parameter int V_ACTIVE = int'(VGA_640x480_60.v.active),
    parameter int V_FP     = int'(VGA_640x480_60.v.fp),
    parameter int V_SYNC   = int'(VGA_640x480_60.v.sync),
    parameter int V_BP     = int'(VGA_640x480_60.v.bp),
    parameter int HS_POL   = 0,
    parameter int VS_POL   = 0,
    parameter int SCALE    = 2,
    parameter int RD_LAT   = 1,
    parameter int ADDR_W   = 17,
    parameter int COLOR_W  = 4
) (
    input  logic                   pclk,
    input  logic                   rst_n,
    input  logic                   en,
`ifdef TEST_PATTERN_EN
    input  logic                   test_mode,
`endif
    input  logic [3*COLOR_W-1:0]   r_data,
    output logic [ADDR_W-1:0]      d_r_addr,
    output logic                   hsync,
    output logic                   vsync,
    output logic                   de,
    output logic [COLOR_W-1:0]     red_bits,
    output logic [COLOR_W-1:0]     green_bits,
    output logic [COLOR_W-1:0]     blue_bits,
    output logic                   frame_start,
    output logic                   line_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HC_W    = $clog2(H_TOTAL);
    localparam int VC_W    = $clog2(V_TOTAL);
    localparam int SUB_W   = (SCALE > 1) ? scale_shift(SCALE) : 1;

    localparam logic [HC_W-1:0]   H_ACT_N  = HC_W'(H_ACTIVE);
    localparam logic [HC_W-1:0]   H_LAST_A = HC_W'(H_ACTIVE - 1);
    localparam logic [HC_W-1:0]   H_SYNC_B = HC_W'(H_ACTIVE + H_FP);
    localparam logic [HC_W-1:0]   H_SYNC_E = HC_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [HC_W-1:0]   H_LAST   = HC_W'(H_TOTAL - 1);
    localparam logic [VC_W-1:0]   V_ACT_N  = VC_W'(V_ACTIVE);
    localparam logic [VC_W-1:0]   V_LAST_A = VC_W'(V_ACTIVE - 1);
    localparam logic [VC_W-1:0]   V_SYNC_B = VC_W'(V_ACTIVE + V_FP);
    localparam logic [VC_W-1:0]   V_SYNC_E = VC_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [VC_W-1:0]   V_LAST   = VC_W'(V_TOTAL - 1);
    localparam logic [SUB_W-1:0]  SUB_LAST = SUB_W'(SCALE - 1);
    localparam logic [ADDR_W-1:0] LINE_WORDS = ADDR_W'(H_ACTIVE / SCALE);
    localparam logic HS_ACT = (HS_POL != 0);
    localparam logic VS_ACT = (VS_POL != 0);

`ifdef TEST_PATTERN_EN
    localparam int PIPE_W = 9;
`else
    localparam int PIPE_W = 5;
`endif

    logic [HC_W-1:0]   r_h_cnt;
    logic [VC_W-1:0]   r_v_cnt;
    logic [SUB_W-1:0]  r_x_sub;
    logic [SUB_W-1:0]  r_y_sub;
    logic [ADDR_W-1:0] r_line_base;

    logic w_h_act, w_v_act, w_act, w_h_last, w_v_last;
    logic w_hs_raw, w_vs_raw, w_fs_raw, w_ls_raw;
    logic [PIPE_W-1:0]    w_pipe_in;
    logic [PIPE_W-1:0]    w_pipe_out;
    logic [3*COLOR_W-1:0] w_pix;

    assign w_h_act  = (r_h_cnt < H_ACT_N);
    assign w_v_act  = (r_v_cnt < V_ACT_N);
    assign w_act    = w_h_act && w_v_act;
    assign w_h_last = (r_h_cnt == H_LAST);
    assign w_v_last = (r_v_cnt == V_LAST);
    assign w_hs_raw = (r_h_cnt >= H_SYNC_B) && (r_h_cnt < H_SYNC_E);
    assign w_vs_raw = (r_v_cnt >= V_SYNC_B) && (r_v_cnt < V_SYNC_E);
    assign w_fs_raw = (r_h_cnt == '0) && (r_v_cnt == '0);
    assign w_ls_raw = (r_h_cnt == '0) && w_v_act;

    // Address walks x_sub/y_sub sub-counters; a repeated line rewinds to line_base.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            r_h_cnt     <= '0;
            r_v_cnt     <= '0;
            r_x_sub     <= '0;
            r_y_sub     <= '0;
            r_line_base <= '0;
            d_r_addr    <= '0;
        end else if (en) begin
            if (w_h_last) begin
                r_h_cnt <= '0;
                r_v_cnt <= w_v_last ? '0 : r_v_cnt + 1'b1;
            end else begin
                r_h_cnt <= r_h_cnt + 1'b1;
            end

            if (w_h_last && w_v_last) begin
                r_x_sub     <= '0;
                r_y_sub     <= '0;
                r_line_base <= '0;
                d_r_addr    <= '0;
            end else if (w_act) begin
                if (r_h_cnt == H_LAST_A) begin
                    r_x_sub <= '0;
                    if (r_y_sub == SUB_LAST) begin
                        r_y_sub <= '0;
                        // Last buffer line wraps straight to 0 so no address past the buffer is issued
                        if (r_v_cnt == V_LAST_A) begin
                            r_line_base <= '0;
                            d_r_addr    <= '0;
                        end else begin
                            r_line_base <= r_line_base + LINE_WORDS;
                            d_r_addr    <= r_line_base + LINE_WORDS;
                        end
                    end else begin
                        r_y_sub  <= r_y_sub + 1'b1;
                        d_r_addr <= r_line_base;
                    end
                end else if (r_x_sub == SUB_LAST) begin
                    r_x_sub  <= '0;
                    d_r_addr <= d_r_addr + 1'b1;
                end else begin
                    r_x_sub <= r_x_sub + 1'b1;
                end
            end
        end
    end

`ifdef TEST_PATTERN_EN
    logic [2:0] w_bar;
    logic [2:0] w_mask;
    assign w_bar     = 3'((int'(r_h_cnt) * 8) / H_ACTIVE);
    assign w_pipe_in = {test_mode, w_bar, w_fs_raw, w_ls_raw, w_act, w_hs_raw, w_vs_raw};
    assign w_mask    = bar_rgb(w_pipe_out[7:5]);
    assign w_pix     = w_pipe_out[8]
                     ? {{COLOR_W{w_mask[2]}}, {COLOR_W{w_mask[1]}}, {COLOR_W{w_mask[0]}}}
                     : r_data;
`else
    assign w_pipe_in = {w_fs_raw, w_ls_raw, w_act, w_hs_raw, w_vs_raw};
    assign w_pix     = r_data;
`endif

    // First RD_LAT stages cover the read; the output register below adds the final cycle.
    sync_delay #(
        .DEPTH (RD_LAT),
        .WIDTH (PIPE_W)
    ) u_align (
        .i_clk   (pclk),
        .i_rst_n (rst_n),
        .i_en    (en),
        .i_d     (w_pipe_in),
        .o_q     (w_pipe_out)
    );

    logic                 r_hsync, r_vsync, r_de, r_fs, r_ls;
    logic [3*COLOR_W-1:0] r_rgb;

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            r_hsync <= ~HS_ACT;
            r_vsync <= ~VS_ACT;
            r_de    <= 1'b0;
            r_fs    <= 1'b0;
            r_ls    <= 1'b0;
            r_rgb   <= '0;
        end else if (en) begin
            r_hsync <= w_pipe_out[1] ? HS_ACT : ~HS_ACT;
            r_vsync <= w_pipe_out[0] ? VS_ACT : ~VS_ACT;
            r_de    <= w_pipe_out[2];
            r_fs    <= w_pipe_out[4];
            r_ls    <= w_pipe_out[3];
            r_rgb   <= w_pipe_out[2] ? w_pix : '0;
        end
    end

    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign de          = r_de;
    assign frame_start = r_fs;
    assign line_start  = r_ls;
    assign red_bits    = r_rgb[3*COLOR_W-1:2*COLOR_W];
    assign green_bits  = r_rgb[2*COLOR_W-1:COLOR_W];
    assign blue_bits   = r_rgb[COLOR_W-1:0];

endmodule

// File: tb/tb_vga_scan_gen.sv
// Directed bench for vga_scan_gen on a 16x8-position raster (8x4 visible, SCALE=2, RD_LAT=2).
module tb_vga_scan_gen;

    localparam int H_ACTIVE = 8;
    localparam int V_ACTIVE = 4;
    localparam int H_TOTAL  = 16;
    localparam int F_TOTAL  = 128;
    localparam int LAT      = 3;

    logic        pclk;
    logic        rst_n;
    logic        en;
    logic [11:0] r_data = '0;
    logic [2:0]  m_stage = '0;
    logic [2:0]  d_r_addr;
    logic        hsync, vsync, de, frame_start, line_start;
    logic [3:0]  red_bits, green_bits, blue_bits;
`ifdef TEST_PATTERN_EN
    logic        test_mode;
`endif

    int n        = 0;
    int n_checks = 0;
    int n_err    = 0;
    bit exp_tm   = 1'b0;

    // Hand-written address tables: visible line base, and start held through each line's blanking
    int          act_base[4]   = '{0, 0, 4, 4};
    int          next_start[8] = '{0, 4, 4, 0, 0, 0, 0, 0};
    logic [11:0] bar_word[8]   = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0,
                                   12'hF0F, 12'hF00, 12'h00F, 12'h000};

    vga_scan_gen #(
        .H_ACTIVE (8), .H_FP (2), .H_SYNC (3), .H_BP (3),
        .V_ACTIVE (4), .V_FP (1), .V_SYNC (2), .V_BP (1),
        .HS_POL (0), .VS_POL (0), .SCALE (2), .RD_LAT (2),
        .ADDR_W (3), .COLOR_W (4)
    ) dut (
        .pclk        (pclk),
        .rst_n       (rst_n),
        .en          (en),
`ifdef TEST_PATTERN_EN
        .test_mode   (test_mode),
`endif
        .r_data      (r_data),
        .d_r_addr    (d_r_addr),
        .hsync       (hsync),
        .vsync       (vsync),
        .de          (de),
        .red_bits    (red_bits),
        .green_bits  (green_bits),
        .blue_bits   (blue_bits),
        .frame_start (frame_start),
        .line_start  (line_start)
    );

    initial begin
        pclk = 1'b0;
        forever #5 pclk = ~pclk;
    end

    function automatic logic [11:0] rd_word(input logic [2:0] a);
        return {1'b0, a, 1'b1, a, ~{1'b0, a}};
    endfunction

    // Two-cycle frame-buffer read port, clock-enabled together with the generator
    always @(posedge pclk) begin
        if (en) begin
            m_stage <= d_r_addr;
            r_data  <= rd_word(m_stage);
        end
    end

    function automatic int exp_addr(input int p);
        int h;
        int v;
        h = p % H_TOTAL;
        v = p / H_TOTAL;
        if (v < V_ACTIVE && h < H_ACTIVE) return act_base[v] + h / 2;
        if (v < V_ACTIVE) return next_start[v];
        return 0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s n=%0d: observed=%0h expected=%0h", tag, n, obs, exp);
        end
    endtask

    task automatic check_all(input string ph);
        int q, hq, vq;
        logic de_e, hs_e, vs_e, fs_e, ls_e;
        logic [11:0] rgb_e;
        de_e = 1'b0; hs_e = 1'b1; vs_e = 1'b1; fs_e = 1'b0; ls_e = 1'b0; rgb_e = '0;
        if (n >= LAT) begin
            q  = (n - LAT) % F_TOTAL;
            hq = q % H_TOTAL;
            vq = q / H_TOTAL;
            de_e = (hq < H_ACTIVE) && (vq < V_ACTIVE);
            hs_e = !(hq >= 10 && hq < 13);
            vs_e = !(vq >= 5 && vq < 7);
            fs_e = (q == 0);
            ls_e = (hq == 0) && (vq < V_ACTIVE);
            if (de_e) rgb_e = exp_tm ? bar_word[hq] : rd_word(3'(exp_addr(q)));
        end
        chk({ph, "/addr"},  32'(d_r_addr), 32'(exp_addr(n % F_TOTAL)));
        chk({ph, "/de"},    32'(de), 32'(de_e));
        chk({ph, "/hsync"}, 32'(hsync), 32'(hs_e));
        chk({ph, "/vsync"}, 32'(vsync), 32'(vs_e));
        chk({ph, "/fs"},    32'(frame_start), 32'(fs_e));
        chk({ph, "/ls"},    32'(line_start), 32'(ls_e));
        chk({ph, "/rgb"},   32'({red_bits, green_bits, blue_bits}), 32'(rgb_e));
    endtask

    task automatic step(input string ph);
        @(posedge pclk);
        if (en && rst_n) n++;
        @(negedge pclk);
        check_all(ph);
    endtask

    initial begin
        rst_n = 1'b0;
        en    = 1'b0;
`ifdef TEST_PATTERN_EN
        test_mode = 1'b0;
`endif
        repeat (3) @(negedge pclk);
        check_all("reset");

        rst_n = 1'b1;
        en    = 1'b1;
        repeat (150) step("run");

        // n=150 sits mid visible line 1; freeze, then resume
        en = 1'b0;
        repeat (50) step("hold");
        en = 1'b1;
        repeat (146) step("resume");

        // n=296 is line 2, h=8 with de still high from the pipeline; reset between edges
        #2 rst_n = 1'b0;
        n = 0;
        #1;
        chk("async_rst/addr",  32'(d_r_addr), 32'(0));
        chk("async_rst/de",    32'(de), 32'(0));
        chk("async_rst/hsync", 32'(hsync), 32'(1));
        chk("async_rst/vsync", 32'(vsync), 32'(1));
        chk("async_rst/fs",    32'(frame_start), 32'(0));
        chk("async_rst/ls",    32'(line_start), 32'(0));
        chk("async_rst/rgb",   32'({red_bits, green_bits, blue_bits}), 32'(0));
        @(negedge pclk);
        repeat (3) step("in_rst");
        rst_n = 1'b1;
        repeat (100) step("restart");

`ifdef TEST_PATTERN_EN
        test_mode = 1'b1;
        exp_tm    = 1'b1;
`endif
        repeat (160) step("tail");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/vga_scan_gen.md
Name: vga_scan_gen

Overview:
Parametrised VGA raster generator, successor to the fixed 640x480 timing core. Produces hsync/vsync/data-enable and a frame-buffer read address with integer pixel replication (SCALE), so QVGA or smaller buffers can drive a VGA panel. It absorbs frame-buffer read latency so RGB and syncs leave aligned. It sits between the camera frame-buffer BRAM read port and the VGA pins, clocked by the 25 MHz pixel clock.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync width (lines)
V_BP, 33, vertical back porch (lines)
HS_POL, 0, hsync active level (0 = active-low)
VS_POL, 0, vsync active level
SCALE, 2, pixel/line replication factor; power of 2, 1..8; must divide H_ACTIVE and V_ACTIVE
RD_LAT, 1, frame-buffer read latency in pclk cycles (0..3)
ADDR_W, 17, read address width; must hold (H_ACTIVE/SCALE)*(V_ACTIVE/SCALE)-1
COLOR_W, 4, bits per colour channel

Ports:
pclk  in  1  pixel clock
rst_n  in  1  asynchronous active-low reset
en  in  1  run enable; 0 freezes counters and outputs
r_data  in  3*COLOR_W  frame-buffer pixel {R,G,B}, valid RD_LAT cycles after d_r_addr
d_r_addr  out  ADDR_W  frame-buffer read address
hsync  out  1  horizontal sync, polarity HS_POL
vsync  out  1  vertical sync, polarity VS_POL
de  out  1  data enable (visible pixel)
red_bits  out  COLOR_W  red output
green_bits  out  COLOR_W  green output
blue_bits  out  COLOR_W  blue output
frame_start  out  1  one-cycle pulse, aligned with first visible pixel of frame
line_start  out  1  one-cycle pulse, aligned with first visible pixel of each line

Behaviour:
- One clock (pclk); reset asynchronous, active-low (rst_n). All state async-cleared.
- Reset values: h_cnt=v_cnt=0, d_r_addr=0, hsync=~HS_POL, vsync=~VS_POL, de=0, RGB=0, pulses=0.
- Counters: h_cnt 0..H_TOTAL-1 (H_TOTAL=sum of H params), wraps to 0 and increments v_cnt; v_cnt wraps at V_TOTAL-1. Active region h_cnt<H_ACTIVE and v_cnt<V_ACTIVE; porches follow active, then sync, then back porch.
- Address: no multiplier. x_sub (0..SCALE-1) steps per active pixel; d_r_addr increments when x_sub wraps. line_base register: at end of each active line, if y_sub==SCALE-1 then line_base += H_ACTIVE/SCALE, else d_r_addr returns to line_base (line repeated). At v_cnt wrap, line_base=0, d_r_addr=0. Outside active region d_r_addr holds the next line's start.
- Alignment: raw de/hsync/vsync/pulses delayed RD_LAT+1 cycles; r_data registered once. Total latency counter-to-pin = RD_LAT+1 pclk. RGB forced 0 when delayed de=0.
- en=0: counters, address and pipeline hold; outputs keep last value. en edge mid-line resumes exactly where stopped.
- rst_n asserted mid-frame: immediate return to reset values; after release first pixel is (0,0), frame_start fires RD_LAT+1 cycles later.
- Last pixel of last line: next address is 0, no out-of-range address ever issued (max = buffer size-1).

Optional Feature:
TEST_PATTERN_EN: when defined, adds input test_mode (1 bit). test_mode=1 replaces r_data with 8 vertical colour bars (bar = h_cnt*8/H_ACTIVE; colours white, yellow, cyan, green, magenta, red, blue, black, full-scale COLOR_W), same latency. When undefined, no port, r_data always used.

Decomposition:
- Package vga_pkg: timing typedef struct (active/fp/sync/bp for H and V), constants VGA_640x480_60 and QVGA_320x240, function clog2-based scale shift.
- Sub-module sync_delay: parameterised DEPTH/WIDTH shift register with en and async reset, used for the sync/de/pulse alignment pipeline.

Test Plan:
- Default params, 1 frame: hsync low for 96 cycles every 800, vsync low 2 lines every 525 -> periods 800 and 420000 pclk exact.
- SCALE=2, H_ACTIVE=8,V_ACTIVE=4, small porches: address sequence line0 = 0,0,1,1,2,2,3,3; line1 repeats 0..3; line2 = 4,4,5,5,6,6,7,7; after frame wraps to 0.
- RD_LAT=2, r_data = registered copy of address: red_bits/green/blue equal address delayed, de high exactly on those cycles, frame_start coincides with pixel 0.
- en held low 50 cycles mid-line -> h_cnt, d_r_addr, outputs frozen; after release sequence continues with no skipped/duplicated pixel.
- rst_n pulsed low at v_cnt=200 asynchronously -> outputs reset same cycle; restart frame identical to first frame.
- TEST_PATTERN_EN defined, test_mode=1 -> pixels 0..79 = 0xFFF, 80..159 = 0xFF0, ..., 560..639 = 0x000.
